// File: rtl/mdio_arbiter_if.sv
// Requester-side and MDIO-master-side signals of the MDIO arbiter.
// The arbiter uses the slave modport; whoever drives requests and the master uses master.
interface mdio_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned IdW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    req;
  logic [32*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    ack;
  logic                err;
  logic [15:0]         rd_data;
  logic [IdW-1:0]      gnt_id;
  logic                busy;
  logic                mdio_start;
  logic [31:0]         t_data;
  logic                mdc;
  logic                data_rdy;
  logic [15:0]         rd_data_in;

  modport master (
    output req, req_data, mdc, data_rdy, rd_data_in,
    input  ack, err, rd_data, gnt_id, busy, mdio_start, t_data
  );

  modport slave (
    input  req, req_data, mdc, data_rdy, rd_data_in,
    output ack, err, rd_data, gnt_id, busy, mdio_start, t_data
  );
endinterface

// File: rtl/mdio_arbiter.sv
// Round-robin arbiter sharing one MDIO master among N_REQ requesters: captures the granted
// frame, starts the master, detects completion or timeout and ACKs the owner.
module mdio_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input logic           clk,
  input logic           rst_n,
  mdio_arbiter_if.slave bus
);
  localparam int unsigned IdW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IdW-1:0] PtrRst = IdW'(N_REQ - 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    StIdle, StCheck, StStart, StWaitWr, StWaitRd, StDone
  } state_e;

  state_e         state_q, state_d;
  logic [IdW-1:0] ptr_q, ptr_d;
  logic [IdW-1:0] gnt_q, gnt_d;
  logic [31:0]    t_data_q, t_data_d;
  logic           err_q, err_d;
  logic [15:0]    rd_data_q, rd_data_d;
  logic [5:0]     rise_cnt_q, rise_cnt_d;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           mdc_q;
  logic           mdc_rise;
  logic           timed_out;
  logic           pick_valid;
  logic [IdW-1:0] pick_id;
  logic [IdW-1:0] idx;
  logic [1:0]     op;
  logic [31:0]    frames [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_frames
    assign frames[i] = bus.req_data[32*i +: 32];
  end

  assign mdc_rise  = bus.mdc & ~mdc_q;
  assign timed_out = (to_cnt_q == ToLast);
  assign op        = t_data_q[29:28];

  // Search starts just after the last owner, so the last owner has lowest priority.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    idx        = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = IdW'((32'(ptr_q) + k) % N_REQ);
      if (!pick_valid && bus.req[idx]) begin
        pick_valid = 1'b1;
        pick_id    = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    t_data_d   = t_data_q;
    err_d      = err_q;
    rd_data_d  = rd_data_q;
    rise_cnt_d = rise_cnt_q;
    to_cnt_d   = to_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gnt_d    = pick_id;
          t_data_d = frames[pick_id];
          state_d  = StCheck;
        end
      end
      StCheck: begin
        if (op == 2'b01 || op == 2'b10) begin
          state_d = StStart;
        end else begin
          err_d     = 1'b1;
          rd_data_d = 16'hFFFF;
          state_d   = StDone;
        end
      end
      StStart: begin
        rise_cnt_d = '0;
        to_cnt_d   = '0;
        state_d    = (op == 2'b10) ? StWaitRd : StWaitWr;
      end
      StWaitWr: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (mdc_rise) rise_cnt_d = rise_cnt_q + 6'd1;
        // Completion is tested first so it wins over a simultaneous timeout.
        if (mdc_rise && rise_cnt_q == 6'd31) begin
          err_d   = 1'b0;
          state_d = StDone;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StWaitRd: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (bus.data_rdy) begin
          err_d     = 1'b0;
          rd_data_d = bus.rd_data_in;
          state_d   = StDone;
        end else if (timed_out) begin
          err_d     = 1'b1;
          rd_data_d = 16'hFFFF;
          state_d   = StDone;
        end
      end
      StDone: begin
        ptr_d   = gnt_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= PtrRst;
      gnt_q      <= '0;
      t_data_q   <= '0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      rise_cnt_q <= '0;
      to_cnt_q   <= '0;
      mdc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      t_data_q   <= t_data_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
      rise_cnt_q <= rise_cnt_d;
      to_cnt_q   <= to_cnt_d;
      mdc_q      <= bus.mdc;
    end
  end

  always_comb begin
    bus.ack = '0;
    if (state_q == StDone) bus.ack[gnt_q] = 1'b1;
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.mdio_start = (state_q == StStart);
  assign bus.err        = err_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.gnt_id     = gnt_q;
  assign bus.t_data     = t_data_q;
endmodule

// File: tb/tb_mdio_arbiter.sv
// Randomized self-checking bench for mdio_arbiter against a round-robin/timing model.
// Outputs are observed 1 time unit after each rising edge; cycle numbers count those edges.
module tb_mdio_arbiter;
  localparam int NReq  = 4;
  localparam int ToCyc = 64;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   m_ptr;
  logic [15:0] m_rd;
  int   w1_start, w1_ack;

  mdio_arbiter_if #(.N_REQ(NReq)) bus ();

  mdio_arbiter #(
    .N_REQ      (NReq),
    .TIMEOUT_CYC(ToCyc)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cap_cyc;
    int          start_cyc;
    int          ack_cyc;
    int          start_cnt;
    int          ack_cnt;
    int          gnt_v;
    logic [3:0]  ack_v;
    logic        err_v;
    logic [15:0] rd_v;
    logic [31:0] tdata_v;
    bit          tdata_moved;
    bit          multi_ack;
    bit          busy_at_ack;
    bit          busy_after;
  } obs_t;

  // Round-robin rule: first requester after the last owner, wrapping.
  function automatic int pick(input int p, input logic [3:0] m);
    for (int k = 1; k <= NReq; k++)
      if (((m >> ((p + k) % NReq)) & 4'd1) != 4'd0) return (p + k) % NReq;
    return -1;
  endfunction

  // Cycles from capture to ACK. The nth MDC rise is sampled d+2n-1 cycles after MDIO_START
  // is seen; DATA_RDY raised rd cycles after MDIO_START is sampled rd+1 cycles after it.
  function automatic int exp_ack(input logic [1:0] op, input int d, input int n, input int rd,
                                 output bit e);
    if (op == 2'b01) begin
      if (n >= 32 && d + 63 <= ToCyc + 1) begin e = 1'b0; return 1 + d + 63; end
    end else if (op == 2'b10) begin
      if (rd >= 1 && rd + 1 <= ToCyc + 1) begin e = 1'b0; return 2 + rd; end
    end else begin
      e = 1'b1; return 1;
    end
    e = 1'b1;
    return 2 + ToCyc;
  endfunction

  task automatic set_frame(input int i, input logic [31:0] f);
    bus.req_data[32*i +: 32] = f;
  endtask

  // Plays the MDIO master for one transaction and records what the DUT did.
  task automatic serve(input int d, input int n_rises, input int rd, input logic [15:0] rdv,
                       input bit drop_owner, output obs_t o);
    int  cyc = 0;
    int  k;
    bit  done = 1'b0;
    o = '{default: 0};
    o.cap_cyc = -1; o.start_cyc = -1; o.ack_cyc = -1;
    while (!done && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      if (o.cap_cyc < 0 && bus.busy) begin
        o.cap_cyc = cyc; o.gnt_v = int'(bus.gnt_id); o.tdata_v = bus.t_data;
      end
      if (o.cap_cyc >= 0 && o.ack_cyc < 0 && bus.t_data !== o.tdata_v) o.tdata_moved = 1'b1;
      if (bus.mdio_start) begin
        o.start_cnt++;
        if (o.start_cyc < 0) o.start_cyc = cyc;
      end
      if (bus.ack != '0) begin
        o.ack_cnt++;
        if (!$onehot(bus.ack)) o.multi_ack = 1'b1;
        if (o.ack_cyc < 0) begin
          o.ack_cyc = cyc; o.ack_v = bus.ack; o.err_v = bus.err; o.rd_v = bus.rd_data;
          o.busy_at_ack = bus.busy;
          if (drop_owner) bus.req[o.gnt_v] = 1'b0;
        end
      end else if (o.ack_cyc >= 0) begin
        o.busy_after = bus.busy; done = 1'b1;
      end
      bus.mdc = 1'b0; bus.data_rdy = 1'b0; bus.rd_data_in = 16'($urandom);
      if (o.start_cyc >= 0 && o.ack_cyc < 0) begin
        k = cyc - o.start_cyc - d;
        if (k >= 0 && k < 2 * n_rises && k % 2 == 0) bus.mdc = 1'b1;
        if (rd >= 0 && cyc - o.start_cyc == rd) begin
          bus.data_rdy = 1'b1; bus.rd_data_in = rdv;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0; bus.req_data = '0; bus.mdc = 1'b0; bus.data_rdy = 1'b0; bus.rd_data_in = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_ptr = NReq - 1; m_rd = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = '0; bus.req_data = '0; bus.mdc = 1'b0; bus.data_rdy = 1'b0; bus.rd_data_in = '0;
    repeat (2) @(posedge clk); #1;
    total++;
    if ({bus.ack, bus.err, bus.rd_data, bus.gnt_id, bus.busy, bus.mdio_start, bus.t_data} !== '0)
    begin
      bad++; $display("FAIL reset_outputs: got ack=%b busy=%b t_data=%h want all zero",
                      bus.ack, bus.busy, bus.t_data);
    end
    rst_n = 1'b1; m_ptr = NReq - 1; m_rd = '0;
    repeat (2) @(posedge clk); #1;
    total++;
    if ({bus.ack, bus.busy, bus.mdio_start} !== 6'b0) begin
      bad++; $display("FAIL reset_idle: got ack=%b busy=%b start=%b want 0", bus.ack, bus.busy,
                      bus.mdio_start);
    end
  endtask

  task automatic test_write(input bit again);
    obs_t o;
    bit   e;
    int   off;
    bus.req_data = '0;
    set_frame(0, 32'h508A_ABCD);
    bus.req = 4'b0001;
    serve(1, 32, -1, 16'h0, 1'b1, o);
    off = exp_ack(2'b01, 1, 32, -1, e);
    total++;
    if (o.cap_cyc !== 1 || o.gnt_v !== pick(m_ptr, 4'b0001)) begin
      bad++; $display("FAIL wr_capture: got cyc=%0d gnt=%0d want cyc=1 gnt=0", o.cap_cyc, o.gnt_v);
    end
    total++;
    if (o.tdata_v !== 32'h508A_ABCD || o.tdata_moved) begin
      bad++; $display("FAIL wr_tdata: got %h moved=%0d want 508aabcd stable", o.tdata_v,
                      o.tdata_moved);
    end
    total++;
    if (o.start_cnt !== 1 || o.start_cyc !== o.cap_cyc + 1) begin
      bad++; $display("FAIL wr_start: got pulses=%0d at %0d want 1 at %0d", o.start_cnt,
                      o.start_cyc, o.cap_cyc + 1);
    end
    total++;
    if (o.ack_v !== 4'b0001 || o.ack_cyc - o.cap_cyc !== off || o.ack_cnt !== 1) begin
      bad++; $display("FAIL wr_ack: got %b after %0d (%0d cyc) want 0001 after %0d (1 cyc)",
                      o.ack_v, o.ack_cyc - o.cap_cyc, o.ack_cnt, off);
    end
    total++;
    if ({o.err_v, o.rd_v} !== {e, m_rd} || !o.busy_at_ack || o.busy_after) begin
      bad++; $display("FAIL wr_result: got err=%b rd=%h busy=%0d/%0d want err=%b rd=%h busy=1/0",
                      o.err_v, o.rd_v, o.busy_at_ack, o.busy_after, e, m_rd);
    end
    if (again) begin
      total++;
      if (o.start_cyc !== w1_start || o.ack_cyc !== w1_ack) begin
        bad++; $display("FAIL wr_repeat: got start=%0d ack=%0d want start=%0d ack=%0d",
                        o.start_cyc, o.ack_cyc, w1_start, w1_ack);
      end
    end else begin
      w1_start = o.start_cyc; w1_ack = o.ack_cyc;
    end
    m_ptr = 0;
  endtask

  task automatic test_read();
    obs_t o;
    bit   e;
    int   rd, off;
    rd = int'($urandom_range(1, 30));
    set_frame(1, 32'h608A_0000);
    bus.req = 4'b0010;
    serve(1, 0, rd, 16'h1234, 1'b1, o);
    off = exp_ack(2'b10, 1, 0, rd, e);
    m_rd = 16'h1234;
    total++;
    if (o.ack_v !== 4'b0010 || o.ack_cyc - o.cap_cyc !== off || o.gnt_v !== 1) begin
      bad++; $display("FAIL rd_ack: got %b after %0d gnt=%0d want 0010 after %0d gnt=1", o.ack_v,
                      o.ack_cyc - o.cap_cyc, o.gnt_v, off);
    end
    total++;
    if ({o.err_v, o.rd_v} !== {e, m_rd} || o.start_cnt !== 1) begin
      bad++; $display("FAIL rd_result: got err=%b rd=%h starts=%0d want err=0 rd=1234 starts=1",
                      o.err_v, o.rd_v, o.start_cnt);
    end
    m_ptr = 1;
  endtask

  task automatic test_invalid();
    obs_t        o;
    logic [31:0] f;
    for (int r = 0; r < 2; r++) begin
      f = '0;
      if (r == 1) begin f = $urandom; f[29:28] = 2'b11; end
      set_frame(2, f);
      bus.req = 4'b0100;
      serve(1, 32, 3, 16'h5A5A, 1'b1, o);
      m_rd = 16'hFFFF;
      total++;
      if (o.ack_v !== 4'b0100 || o.ack_cyc - o.cap_cyc !== 1 || o.start_cnt !== 0) begin
        bad++; $display("FAIL inv_ack: got %b after %0d starts=%0d want 0100 after 1 starts=0",
                        o.ack_v, o.ack_cyc - o.cap_cyc, o.start_cnt);
      end
      total++;
      if ({o.err_v, o.rd_v} !== {1'b1, m_rd}) begin
        bad++; $display("FAIL inv_result: got err=%b rd=%h want err=1 rd=ffff", o.err_v, o.rd_v);
      end
      m_ptr = 2;
    end
  endtask

  task automatic test_timeout();
    // requester, op, d, n_rises, rd: read timeout, write finishing on the timeout edge,
    // read finishing on the timeout edge, write with too few MDC rises
    int          t_id [4] = '{0, 3, 1, 2};
    logic [1:0]  t_op [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    int          t_d  [4] = '{1, 2, 1, 1};
    int          t_n  [4] = '{32, 32, 0, 20};
    int          t_rd [4] = '{-1, -1, 64, -1};
    obs_t        o;
    bit          e;
    int          off;
    logic [31:0] f;
    logic [15:0] rdv;
    for (int s = 0; s < 4; s++) begin
      f = $urandom; f[29:28] = t_op[s]; rdv = 16'($urandom);
      set_frame(t_id[s], f);
      bus.req = 4'(1 << t_id[s]);
      serve(t_d[s], t_n[s], t_rd[s], rdv, 1'b1, o);
      off = exp_ack(t_op[s], t_d[s], t_n[s], t_rd[s], e);
      if (t_op[s] == 2'b10) m_rd = e ? 16'hFFFF : rdv;
      total++;
      if (o.ack_v !== 4'(1 << t_id[s]) || o.ack_cyc - o.cap_cyc !== off) begin
        bad++; $display("FAIL to_ack[%0d]: got %b after %0d want %b after %0d", s, o.ack_v,
                        o.ack_cyc - o.cap_cyc, 4'(1 << t_id[s]), off);
      end
      total++;
      if ({o.err_v, o.rd_v} !== {e, m_rd}) begin
        bad++; $display("FAIL to_result[%0d]: got err=%b rd=%h want err=%b rd=%h", s, o.err_v,
                        o.rd_v, e, m_rd);
      end
      if (s == 0) begin
        total++;
        if (o.ack_cyc - o.start_cyc !== ToCyc + 1) begin
          bad++; $display("FAIL to_latency: got %0d want %0d", o.ack_cyc - o.start_cyc,
                          ToCyc + 1);
        end
      end
      m_ptr = t_id[s];
    end
  endtask

  task automatic test_random();
    obs_t        o;
    bit          e;
    int          off, w, d, n, rd;
    logic [3:0]  mask;
    logic [31:0] fr [4];
    logic [15:0] rdv;
    logic [1:0]  op;
    for (int it = 0; it < 16; it++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < NReq; i++) begin
        fr[i] = $urandom;
        if ($urandom_range(0, 4) == 0) fr[i][29:28] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
        else fr[i][29:28] = 2'($urandom_range(1, 2));
        set_frame(i, fr[i]);
      end
      bus.req = mask;
      d   = int'($urandom_range(1, 2));
      n   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 31)) : 32;
      rd  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, 64));
      rdv = 16'($urandom);
      w   = pick(m_ptr, mask);
      serve(d, n, rd, rdv, 1'b0, o);
      op  = fr[w][29:28];
      off = exp_ack(op, d, n, rd, e);
      if (op == 2'b10) m_rd = e ? 16'hFFFF : rdv;
      else if (op != 2'b01) m_rd = 16'hFFFF;
      total++;
      if (o.gnt_v !== w || o.ack_v !== 4'(1 << w) || o.tdata_v !== fr[w]) begin
        bad++; $display("FAIL rnd_grant[%0d]: got gnt=%0d ack=%b frame=%h want %0d %b %h", it,
                        o.gnt_v, o.ack_v, o.tdata_v, w, 4'(1 << w), fr[w]);
      end
      total++;
      if (o.ack_cyc - o.cap_cyc !== off || {o.err_v, o.rd_v} !== {e, m_rd}) begin
        bad++; $display("FAIL rnd_result[%0d]: got lat=%0d err=%b rd=%h want %0d %b %h", it,
                        o.ack_cyc - o.cap_cyc, o.err_v, o.rd_v, off, e, m_rd);
      end
      total++;
      if (o.start_cnt !== ((op == 2'b01 || op == 2'b10) ? 1 : 0) || o.tdata_moved ||
          o.multi_ack || o.ack_cnt !== 1 || o.busy_after) begin
        bad++; $display("FAIL rnd_proto[%0d]: got starts=%0d moved=%0d multi=%0d acks=%0d busy=%0d",
                        it, o.start_cnt, o.tdata_moved, o.multi_ack, o.ack_cnt, o.busy_after);
      end
      m_ptr = w;
    end
  endtask

  task automatic test_fairness();
    int          order [6] = '{0, 1, 2, 3, 0, 2};
    obs_t        o;
    logic [31:0] f;
    int          w;
    do_reset();
    for (int i = 0; i < NReq; i++) begin
      f = $urandom; f[29:28] = 2'b10; set_frame(i, f);
    end
    bus.req = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      if (g == 4) bus.req = 4'b0101;
      w = pick(m_ptr, bus.req);
      serve(1, 0, int'($urandom_range(1, 8)), 16'($urandom), 1'b0, o);
      total++;
      if (o.gnt_v !== order[g] || w !== order[g] || o.ack_v !== 4'(1 << order[g]) ||
          o.multi_ack || o.cap_cyc !== 1) begin
        bad++; $display("FAIL fair[%0d]: got gnt=%0d ack=%b multi=%0d cap=%0d want gnt=%0d cap=1",
                        g, o.gnt_v, o.ack_v, o.multi_ack, o.cap_cyc, order[g]);
      end
      m_ptr = o.gnt_v;
    end
  endtask

  task automatic test_reset_mid();
    int seen = -1;
    int acks = 0;
    bus.req_data = '0;
    set_frame(0, 32'h608A_0000);
    bus.req = 4'b0001;
    for (int c = 0; c < 10 && seen < 0; c++) begin
      @(posedge clk); #1;
      if (bus.mdio_start) seen = c;
    end
    total++;
    if (seen < 0) begin
      bad++; $display("FAIL rstmid_start: got no MDIO_START want one within 10 cycles");
    end
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.ack, bus.err, bus.rd_data, bus.gnt_id, bus.busy, bus.mdio_start, bus.t_data} !== '0)
    begin
      bad++; $display("FAIL rstmid_outputs: got ack=%b busy=%b rd=%h t_data=%h want all zero",
                      bus.ack, bus.busy, bus.rd_data, bus.t_data);
    end
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_ptr = NReq - 1; m_rd = '0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.ack != '0 || bus.busy) acks++;
    end
    total++;
    if (acks !== 0) begin
      bad++; $display("FAIL rstmid_noack: got %0d active cycles want 0", acks);
    end
    test_write(1'b1);
  endtask

  initial begin
    test_reset();
    test_write(1'b0);
    test_read();
    test_invalid();
    test_timeout();
    test_random();
    test_fairness();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
